// File: rtl/regfile_sb.sv
// regfile_sb: NREG x DW register file with write-through bypass, optional zero r0, pending scoreboard and clear sweep
module regfile_sb #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wad,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_set_v,
    input  logic [AW-1:0]     i_set_ad,
    input  logic [NRP*AW-1:0] i_rad,
    output logic [NRP*DW-1:0] o_rdata,
    output logic [NRP-1:0]    o_busy
);
    localparam int NREG = 2 ** AW;
    localparam logic [AW:0] LAST = (AW + 1)'(NREG - 1);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;
    logic [AW:0] cnt;
    logic [NREG-1:0] pend, pend_nx;
    logic [DW-1:0] rf [NREG];
    logic run, we_ok, set_ok;
    assign run = state == RUN;
    assign o_ready = run;
    assign we_ok = run && !i_clr && i_we && !(ZERO_R0 != 0 && i_wad == '0);
    assign set_ok = run && !i_clr && i_set_v && !(ZERO_R0 != 0 && i_set_ad == '0);
    always_comb begin
        state_nx = run ? (i_clr ? CLEAR : RUN) : (cnt == LAST ? RUN : CLEAR);
        pend_nx = (!run || i_clr) ? '0 : pend;
        if (we_ok) pend_nx[i_wad] = 1'b0;
        if (set_ok) pend_nx[i_set_ad] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt <= '0;
            pend <= '0;
        end else begin
            state <= state_nx;
            cnt <= run ? '0 : cnt + 1'b1;
            pend <= pend_nx;
        end
    end
    // array has no reset; the sweep zeroes it one entry per cycle
    always_ff @(posedge clk) begin
        if (!run) rf[cnt[AW-1:0]] <= '0;
        else if (we_ok) rf[i_wad] <= i_wdata;
    end
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic zero, byp;
        assign ra = i_rad[p*AW +: AW];
        assign zero = ZERO_R0 != 0 && ra == '0;
        assign byp = i_we && i_wad == ra;
        assign o_rdata[p*DW +: DW] = (!run || zero) ? '0 : byp ? i_wdata : rf[ra];
        assign o_busy[p] = run && !zero && !byp && pend[ra];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table vectors, hand sequences and randomized checks against a behavioural model
module tb_regfile_sb;
    logic        clk = 0, rst_n = 0, i_clr = 0, i_we = 0, i_set_v = 0, o_ready;
    logic [4:0]  i_wad = 0, i_set_ad = 0;
    logic [31:0] i_wdata = 0;
    logic [9:0]  i_rad = 0;
    logic [63:0] o_rdata;
    logic [1:0]  o_busy;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .o_ready(o_ready),
        .i_we(i_we), .i_wad(i_wad), .i_wdata(i_wdata),
        .i_set_v(i_set_v), .i_set_ad(i_set_ad),
        .i_rad(i_rad), .o_rdata(o_rdata), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    int          m_sweep;

    typedef struct {
        logic        we;
        logic [4:0]  wad;
        logic [31:0] wdata;
        logic        set_v;
        logic [4:0]  sad;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic        b0, b1;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // architectural view: sweeping -> nothing visible; r0 reads zero; bypass beats array
    function automatic logic [32:0] model_rd(input logic [4:0] a);
        if (m_sweep != 0 || a == 0) return '0;
        if (i_we && i_wad == a) return {1'b0, i_wdata};
        return {m_pend[a], m_rf[a]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 0;
            m_pend[i] = 0;
        end
        m_sweep = 32;
    endtask

    task automatic model_update();
        if (m_sweep > 0) m_sweep--;
        else if (i_clr) model_clear();
        else begin
            if (i_we && i_wad != 0) begin
                m_rf[i_wad] = i_wdata;
                m_pend[i_wad] = 0;
            end
            if (i_set_v && i_set_ad != 0) m_pend[i_set_ad] = 1;
        end
    endtask

    task automatic check_outputs(input string nm);
        logic [32:0] r;
        #1;
        chk({nm, "_ready"}, 32'(o_ready), 32'(m_sweep == 0));
        for (int p = 0; p < 2; p++) begin
            r = model_rd(i_rad[p*5 +: 5]);
            chk($sformatf("%s_rdata%0d", nm, p), o_rdata[p*32 +: 32], r[31:0]);
            chk($sformatf("%s_busy%0d", nm, p), 32'(o_busy[p]), 32'(r[32]));
        end
    endtask

    task automatic clock();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        i_clr = 0; i_we = 0; i_set_v = 0; i_wad = 0; i_set_ad = 0; i_wdata = 0; i_rad = 0;
    endtask

    task automatic ready_latency(input string nm);
        int n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(n), 32'd32);
        m_sweep = 0;
        @(negedge clk);
    endtask

    task automatic reset_release();
        idle();
        rst_n = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
        tv[1]  = '{0, 0, 0,            0, 0, 5, 7, 32'hDEADBEEF, 0, 0, 0};
        tv[2]  = '{1, 0, 32'h1234,     1, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0};
        tv[3]  = '{0, 0, 0,            1, 7, 0, 7, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 0,            0, 0, 0, 7, 0, 0, 0, 1};
        tv[5]  = '{1, 7, 32'h55,       0, 0, 7, 7, 32'h55, 32'h55, 0, 0};
        tv[6]  = '{0, 0, 0,            0, 0, 7, 7, 32'h55, 32'h55, 0, 0};
        tv[7]  = '{1, 7, 32'hAAAA5555, 1, 7, 7, 5, 32'hAAAA5555, 32'hDEADBEEF, 0, 0};
        tv[8]  = '{0, 0, 0,            0, 0, 7, 7, 32'hAAAA5555, 32'hAAAA5555, 1, 1};
        tv[9]  = '{1, 9, 32'h77,       1, 3, 3, 9, 0, 32'h77, 0, 0};
        tv[10] = '{0, 0, 0,            0, 0, 3, 9, 0, 32'h77, 1, 0};

        // reset sweep length, then every register reads zero and idle
        @(negedge clk);
        reset_release();
        ready_latency("t1_ready_latency");
        for (int a = 0; a < 32; a += 2) begin
            i_rad = {5'(a + 1), 5'(a)};
            check_outputs("t1_zero");
            clock();
        end
        idle();

        // bypass, r0, scoreboard set/clear and set-wins cases
        for (int i = 0; i < 11; i++) begin
            i_we = tv[i].we; i_wad = tv[i].wad; i_wdata = tv[i].wdata;
            i_set_v = tv[i].set_v; i_set_ad = tv[i].sad; i_rad = {tv[i].r1, tv[i].r0};
            #1;
            chk($sformatf("tv%0d_ready", i), 32'(o_ready), 32'd1);
            chk($sformatf("tv%0d_rdata0", i), o_rdata[31:0], tv[i].d0);
            chk($sformatf("tv%0d_rdata1", i), o_rdata[63:32], tv[i].d1);
            chk($sformatf("tv%0d_busy0", i), 32'(o_busy[0]), 32'(tv[i].b0));
            chk($sformatf("tv%0d_busy1", i), 32'(o_busy[1]), 32'(tv[i].b1));
            clock();
        end
        idle();

        // fill with pending marks, clear with a colliding write/set, sweep ignores ops
        for (int a = 1; a < 32; a++) begin
            i_we = 1; i_wad = 5'(a); i_wdata = $urandom;
            i_set_v = 1; i_set_ad = 5'(32 - a); i_rad = {5'(a), 5'(32 - a)};
            check_outputs("t5_fill");
            clock();
        end
        i_we = 1; i_wad = 3; i_wdata = 32'hCAFEF00D; i_set_v = 1; i_set_ad = 4; i_clr = 1; i_rad = {5'd4, 5'd6};
        check_outputs("t5_clr");
        clock();
        i_clr = 0;
        for (int c = 0; c < 32; c++) begin
            i_we = 1; i_wad = 5'($urandom); i_wdata = $urandom;
            i_set_v = 1; i_set_ad = 5'($urandom); i_rad = 10'($urandom);
            check_outputs("t5_sweep");
            clock();
        end
        idle();
        for (int a = 0; a < 32; a += 2) begin
            i_rad = {5'(a + 1), 5'(a)};
            check_outputs("t5_zero");
            clock();
        end

        // reset asserted mid-sweep restarts the full sweep
        reset_release();
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        chk("t6_ready_in_reset", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst_n = 1;
        ready_latency("t6_ready_latency");

        // randomized traffic, narrow address range for frequent collisions
        for (int c = 0; c < 2000; c++) begin
            i_we = 1'($urandom_range(0, 1));
            i_wad = 5'($urandom_range(0, 7));
            i_wdata = $urandom;
            i_set_v = $urandom_range(0, 9) < 3;
            i_set_ad = 5'($urandom_range(0, 7));
            i_rad = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            i_clr = $urandom_range(0, 99) == 0;
            check_outputs("rnd");
            clock();
        end
        idle();

        // reset in the middle of RUN
        rst_n = 0;
        model_clear();
        #1;
        chk("run_reset_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst_n = 1;
        ready_latency("run_reset_latency");
        check_outputs("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
